// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving the selector of a shared bus register.
// Grants may be extended by lock for bursts, capped at max_hold cycles.
module bus_arbiter #(
    parameter int count    = 4,
    parameter int max_hold = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [count-1:0]                 request,
    input  logic                             lock,
    output logic [count-1:0]                 grant,
    output logic [$clog2(count + 1)-1:0]     selector,
    output logic                             busy,
    output logic [$clog2(max_hold + 1)-1:0]  hold_count,
    output logic                             state_debug
);

    localparam int SEL_W  = $clog2(count + 1);
    localparam int HOLD_W = $clog2(max_hold + 1);
    localparam int PTR_W  = (count > 1) ? $clog2(count) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    arb_state_t              state, state_n;
    logic [PTR_W-1:0]        ptr, ptr_n;
    logic [PTR_W-1:0]        owner;
    logic [PTR_W-1:0]        scan_idx;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_found;
    logic                    keep_grant;
    logic [count-1:0]        grant_n;
    logic [SEL_W-1:0]        selector_n;
    logic                    busy_n;
    logic [HOLD_W-1:0]       hold_n;

    // Handshake: request[i] is a level held by requester i; grant[i] is the
    // registered answer, and the bus register latches selector one edge later.
    assign owner       = selector[PTR_W-1:0];
    assign state_debug = (state == GRANT);

    // Search upward from the pointer with wrap-around; first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < count; k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % count);
            if (!win_found && request[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign keep_grant = (state == GRANT) && request[owner] && lock &&
                        (hold_count < HOLD_W'(max_hold));

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        grant_n    = grant;
        selector_n = selector;
        busy_n     = busy;
        hold_n     = hold_count;
        if (keep_grant) begin
            hold_n = hold_count + HOLD_W'(1);
        end else if (win_found) begin
            // Release and re-arbitrate on the same edge, no idle bubble.
            state_n    = GRANT;
            grant_n    = {{(count-1){1'b0}}, 1'b1} << win_idx;
            selector_n = SEL_W'(win_idx);
            busy_n     = 1'b1;
            hold_n     = HOLD_W'(1);
            ptr_n      = (win_idx == PTR_W'(count - 1)) ? '0 : win_idx + PTR_W'(1);
        end else begin
            state_n    = IDLE;
            grant_n    = '0;
            selector_n = '1;
            busy_n     = 1'b0;
            hold_n     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            selector   <= '1;
            busy       <= 1'b0;
            hold_count <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            grant      <= grant_n;
            selector   <= selector_n;
            busy       <= busy_n;
            hold_count <= hold_n;
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that owns the selector of a shared bus_register (or buffered_register) and shares that register between `count` requesters.
- Each cycle it decides which source slice the register latches, or drives the all-ones hold code when no requester is granted.
- A lock input lets the current owner keep the bus for bursts, bounded by `max_hold` so that no requester starves.
- Sits between the requesting units and the selector input of the register.

Parameters:
- count, 4, number of requesters; equals the `count` of the driven register; must be >= 2.
- max_hold, 4, maximum consecutive cycles one grant may last; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- request  input  count  bit i high = requester i wants to drive the bus.
- lock  input  1  high = the current owner asks to keep its grant next cycle.
- grant  output  count  one-hot grant, registered; all zero when idle.
- selector  output  $clog2(count + 1)  index of the granted requester, registered; all-ones when idle (register holds).
- busy  output  1  high while any grant is active, registered.
- hold_count  output  $clog2(max_hold + 1)  cycles the current grant has lasted, 0 when idle.

Behaviour:
- Reset (reset == 0 at posedge):
  - grant = 0, selector = all-ones, busy = 0, hold_count = 0.
  - Priority pointer = 0; state = IDLE.
  - Reset overrides every other input, including in the middle of a locked burst.
- Outputs are all registered. A request seen at posedge N produces its grant and selector after posedge N. The driven register latches that source at posedge N+1.
- Arbitration picks the first requesting index at or after the pointer, searching upward with wrap-around from count-1 to 0. The pointer then becomes (winner + 1) mod count.
- State IDLE:
  - No request: stay IDLE with idle outputs.
  - Any request: move to GRANT with grant/selector set to the winner, busy = 1, hold_count = 1.
- State GRANT, owner o. The grant continues only if all of the following hold:
  - request[o] == 1,
  - lock == 1,
  - hold_count < max_hold.
  
  When it continues: same outputs, hold_count + 1, pointer unchanged.
- Otherwise the grant is released and re-arbitrated on the same edge (no idle bubble):
  - Another requester exists: grant it, hold_count = 1.
  - Only o still requests, after lock dropped or hold expired: o is re-granted, hold_count = 1.
  - No requests: go to IDLE, selector = all-ones, grant = 0, busy = 0, hold_count = 0.
- lock is ignored in IDLE and has no effect on a newly issued grant's first cycle.
- When lock == 0 permanently, the grant rotates every cycle among the active requesters.
- max_hold == 1 forces single-cycle grants regardless of lock.
- Exactly one grant bit is set whenever busy == 1. selector never equals all-ones while busy == 1; this is guaranteed because count <= 2^width - 1.
- Request bits that change while not granted affect only the next arbitration.

Test Plan (count = 4, max_hold = 4):
- Reset hold: reset = 0 for 2 cycles with request = 4'b1111 -> grant = 0, selector = 3'b111, busy = 0; release reset -> grant = 4'b0001, selector = 0 after the first posedge.
- Rotation: request = 4'b1111, lock = 0 for 8 cycles -> selector sequence 0, 1, 2, 3, 0, 1, 2, 3; grant stays one-hot throughout.
- Sparse wrap: pointer at 3, request = 4'b0101 -> grant 0 then 2 then 0; indices 1 and 3 are never selected.
- Burst cap: request = 4'b0011, lock = 1 -> requester 0 granted for 4 cycles (hold_count 1, 2, 3, 4), then requester 1 for 4 cycles, then requester 0.
- Early release: owner 2 under lock drops request[2] at hold_count = 2 while request[3] = 1 -> next cycle selector = 3, hold_count = 1, busy stays 1.
- Reset mid-burst: owner 1 with hold_count = 3 and lock = 1, assert reset for 1 cycle -> all outputs idle; the next grant with request = 4'b1111 goes to 0.
